// File: rtl/rls_result_reader_pkg.sv
// Shared definitions for the RLS solution-interface family: state encoding,
// default vector geometry and a constant log2 helper.
package rls_result_reader_pkg;

    localparam int RLS_N_DEFAULT     = 16;
    localparam int RLS_NBITS_DEFAULT = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rls_state_t;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int rls_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rls_result_reader_word.sv
// Combinational word selector over a packed N-word vector; shared by the
// RLS debug readers.
module rls_word_mux
    import rls_result_reader_pkg::*;
#(
    parameter int N     = RLS_N_DEFAULT,
    parameter int nBits = RLS_NBITS_DEFAULT
) (
    input  logic [N*nBits-1:0]     vec,
    input  logic [rls_clog2(N)-1:0] idx,
    output logic [nBits-1:0]        word
);

    assign word = vec[idx*nBits +: nBits];

endmodule

// File: rtl/rls_result_reader.sv
// Captures an RLS solution vector on write and streams it out one word per
// valid/ready handshake, counting delivered frames and flagging dropped ones.
module rls_result_reader
    import rls_result_reader_pkg::*;
#(
    parameter int N         = RLS_N_DEFAULT,
    parameter int nBits     = RLS_NBITS_DEFAULT,
    parameter bit MSW_FIRST = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write,
    input  logic [N*nBits-1:0]      x,
    output logic [nBits-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [rls_clog2(N)-1:0] out_index,
    output logic                    out_last,
    output logic                    busy,
    output logic                    overrun,
    output logic [15:0]             frame_count
);

    localparam int IW = rls_clog2(N);
    localparam logic [IW-1:0] FIRST_IDX = MSW_FIRST ? IW'(N - 1) : '0;
    localparam logic [IW-1:0] LAST_IDX  = MSW_FIRST ? '0 : IW'(N - 1);

    rls_state_t           state;
    logic [N*nBits-1:0]   buf_q;
    logic [N*nBits-1:0]   vec_sel;
    logic [IW-1:0]        cnt_q;
    logic [IW-1:0]        cnt_d;
    logic [nBits-1:0]     word_sel;
    logic                 accept;
    logic                 final_acc;
    logic                 capture;

    assign out_valid = (state == STREAM);
    assign busy      = (state == STREAM);
    assign accept    = (state == STREAM) && out_ready;
    assign final_acc = accept && (cnt_q == LAST_IDX);
    assign capture   = write && ((state == IDLE) || final_acc);

    // Look ahead to the next counter value so out_data is a registered mux
    // output; a capture selects straight from x to avoid a bubble.
    always_comb begin
        vec_sel = buf_q;
        cnt_d   = cnt_q;
        if (capture) begin
            vec_sel = x;
            cnt_d   = FIRST_IDX;
        end else if (accept) begin
            cnt_d = MSW_FIRST ? cnt_q - 1'b1 : cnt_q + 1'b1;
        end
    end

    rls_word_mux #(
        .N     (N),
        .nBits (nBits)
    ) u_word_mux (
        .vec  (vec_sel),
        .idx  (cnt_d),
        .word (word_sel)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            buf_q       <= '0;
            cnt_q       <= '0;
            out_data    <= '0;
            out_index   <= '0;
            out_last    <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (write) begin
                        buf_q     <= x;
                        cnt_q     <= cnt_d;
                        out_index <= cnt_d;
                        out_data  <= word_sel;
                        out_last  <= (cnt_d == LAST_IDX);
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (write && !final_acc) begin
                        overrun <= 1'b1;
                    end
                    if (final_acc) begin
                        frame_count <= frame_count + 16'd1;
                        if (write) begin
                            buf_q     <= x;
                            cnt_q     <= cnt_d;
                            out_index <= cnt_d;
                            out_data  <= word_sel;
                            out_last  <= (cnt_d == LAST_IDX);
                        end else begin
                            out_last <= 1'b0;
                            state    <= IDLE;
                        end
                    end else if (accept) begin
                        cnt_q     <= cnt_d;
                        out_index <= cnt_d;
                        out_data  <= word_sel;
                        out_last  <= (cnt_d == LAST_IDX);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rls_result_reader.sv
// Scoreboard bench: stimulus pushes expected words, negedge monitors pop and
// compare on every accepted handshake.
module tb_rls_result_reader;

    localparam int N = 16;
    localparam int W = 32;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           write0 = 1'b0, write1 = 1'b0;
    logic [N*W-1:0] x0 = '0, x1 = '0;
    logic           ready0 = 1'b0, ready1 = 1'b0;

    logic [31:0] out_data0, out_data1;
    logic        out_valid0, out_valid1;
    logic [3:0]  out_index0, out_index1;
    logic        out_last0, out_last1;
    logic        busy0, busy1;
    logic        overrun0, overrun1;
    logic [15:0] fc0, fc1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    rls_result_reader #(.N(N), .nBits(W), .MSW_FIRST(1'b0)) dut0 (
        .clk(clk), .reset(reset), .write(write0), .x(x0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(ready0),
        .out_index(out_index0), .out_last(out_last0), .busy(busy0),
        .overrun(overrun0), .frame_count(fc0)
    );

    rls_result_reader #(.N(N), .nBits(W), .MSW_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(reset), .write(write1), .x(x1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(ready1),
        .out_index(out_index1), .out_last(out_last1), .busy(busy1),
        .overrun(overrun1), .frame_count(fc1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [N*W-1:0] mk(input logic [31:0] base);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = base + 32'(i);
        return v;
    endfunction

    // Monitor for the LSW-first instance, including stall stability.
    logic        stall0 = 1'b0;
    logic [31:0] hold_d0 = '0;
    logic [3:0]  hold_i0 = '0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            stall0 <= 1'b0;
        end else begin
            if (stall0) begin
                chk("stall_valid0", 32'(out_valid0), 32'd1);
                chk("stall_data0", out_data0, hold_d0);
                chk("stall_index0", 32'(out_index0), 32'(hold_i0));
            end
            if (out_valid0 && ready0) begin
                if (q0.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_word0: got 0x%0h, required no word", out_data0);
                end else begin
                    e = q0.pop_front();
                    chk("data0", out_data0, e.data);
                    chk("index0", 32'(out_index0), 32'(e.idx));
                    chk("last0", 32'(out_last0), 32'(e.last));
                end
            end
            stall0  <= out_valid0 && !ready0;
            hold_d0 <= out_data0;
            hold_i0 <= out_index0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid1 && ready1) begin
            if (q1.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_word1: got 0x%0h, required no word", out_data1);
            end else begin
                e = q1.pop_front();
                chk("data1", out_data1, e.data);
                chk("index1", 32'(out_index1), 32'(e.idx));
                chk("last1", 32'(out_last1), 32'(e.last));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic send0(input logic [31:0] base);
        x0 = mk(base);
        write0 = 1'b1;
        for (int i = 0; i < N; i++) q0.push_back('{base + 32'(i), 4'(i), (i == N - 1)});
        cyc();
        write0 = 1'b0;
    endtask

    task automatic send1(input logic [31:0] base);
        x1 = mk(base);
        write1 = 1'b1;
        for (int i = N - 1; i >= 0; i--) q1.push_back('{base + 32'(i), 4'(i), (i == 0)});
        cyc();
        write1 = 1'b0;
    endtask

    task automatic wait_idle(input bit which, output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (!(which ? busy1 : busy0)) break;
            cyc();
            n++;
        end
        chk("idle_timeout", 32'(which ? busy1 : busy0), 32'd0);
    endtask

    task automatic wait_idx0(input int k);
        for (int i = 0; i < 100; i++) begin
            if (out_valid0 && out_index0 == 4'(k)) break;
            cyc();
        end
        chk("reach_index", 32'(out_index0), 32'(k));
    endtask

    initial begin
        int n;
        #1;
        chk("rst_valid", 32'(out_valid0), 32'd0);
        chk("rst_data", out_data0, 32'd0);
        chk("rst_index", 32'(out_index0), 32'd0);
        chk("rst_last", 32'(out_last0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_overrun", 32'(overrun0), 32'd0);
        chk("rst_fc", 32'(fc0), 32'd0);
        do_reset();

        // 1: plain frame, sink always ready
        ready0 = 1'b1;
        send0(32'h1000_0000);
        chk("latency_valid", 32'(out_valid0), 32'd1);
        chk("first_word", out_data0, 32'h1000_0000);
        wait_idle(1'b0, n);
        chk("frame_cycles", 32'(n), 32'd16);
        chk("t1_fc", 32'(fc0), 32'd1);
        chk("t1_busy", 32'(busy0), 32'd0);

        // 2: backpressure 1,0,0,1
        send0(32'h1000_0000);
        for (int c = 0; c < 300 && busy0; c++) begin
            ready0 = (c % 4 == 0) || (c % 4 == 3);
            cyc();
        end
        ready0 = 1'b1;
        chk("t2_busy", 32'(busy0), 32'd0);
        chk("t2_fc", 32'(fc0), 32'd2);
        chk("t2_overrun", 32'(overrun0), 32'd0);

        // 3: write during word 5 is dropped
        do_reset();
        send0(32'h1000_0000);
        wait_idx0(5);
        x0 = {N{32'hDEAD_BEEF}};
        write0 = 1'b1;
        cyc();
        write0 = 1'b0;
        chk("t3_overrun", 32'(overrun0), 32'd1);
        wait_idle(1'b0, n);
        chk("t3_fc", 32'(fc0), 32'd1);
        chk("t3_overrun_sticky", 32'(overrun0), 32'd1);

        // 4: write on final accept chains without bubble
        do_reset();
        send0(32'h1000_0000);
        wait_idx0(15);
        x0 = mk(32'h3000_0000);
        write0 = 1'b1;
        for (int i = 0; i < N; i++) q0.push_back('{32'h3000_0000 + 32'(i), 4'(i), (i == N - 1)});
        cyc();
        write0 = 1'b0;
        chk("t4_valid", 32'(out_valid0), 32'd1);
        chk("t4_word0", out_data0, 32'h3000_0000);
        chk("t4_index0", 32'(out_index0), 32'd0);
        wait_idle(1'b0, n);
        chk("t4_overrun", 32'(overrun0), 32'd0);
        chk("t4_fc", 32'(fc0), 32'd2);

        // 5: MSW-first instance
        ready1 = 1'b1;
        send1(32'h1000_0000);
        chk("t5_first_word", out_data1, 32'h1000_000F);
        chk("t5_first_index", 32'(out_index1), 32'd15);
        wait_idle(1'b1, n);
        chk("t5_fc", 32'(fc1), 32'd1);

        // 6: async reset mid-frame
        do_reset();
        send0(32'h1000_0000);
        wait_idx0(8);
        reset = 1'b1;
        #1;
        q0.delete();
        chk("t6_valid", 32'(out_valid0), 32'd0);
        chk("t6_data", out_data0, 32'd0);
        chk("t6_index", 32'(out_index0), 32'd0);
        chk("t6_last", 32'(out_last0), 32'd0);
        chk("t6_busy", 32'(busy0), 32'd0);
        chk("t6_fc", 32'(fc0), 32'd0);
        cyc();
        reset = 1'b0;
        send0(32'h1000_0000);
        chk("t6_restart_index", 32'(out_index0), 32'd0);
        wait_idle(1'b0, n);
        chk("t6_fc_after", 32'(fc0), 32'd1);

        cyc();
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
